// File: rtl/link_frame_scheduler_if.sv
// Link-side bundle of the frame scheduler: requester handshake, payload bus and serial pins.
// The master modport is the scheduler's side; the slave modport is the requester/pin side.
interface link_frame_scheduler_if #(
  parameter int NREQ    = 2,
  parameter int FRAME_W = 49
);
   logic [NREQ-1:0]         REQ;
   logic [NREQ*FRAME_W-1:0] REQ_DATA;
   logic [NREQ-1:0]         GNT;
   logic                    S_OUT;
   logic                    SYNC;
   logic                    BUSY;
   logic                    FRAME_DONE;

   modport master (
      input  REQ, REQ_DATA,
      output GNT, S_OUT, SYNC, BUSY, FRAME_DONE
   );

   modport slave (
      output REQ, REQ_DATA,
      input  GNT, S_OUT, SYNC, BUSY, FRAME_DONE
   );
endinterface

// File: rtl/link_frame_scheduler.sv
// Round-robin frame arbiter and MSB-first serialiser for the board-to-board link; SYNC marks the last bit.
// Optional build macro IDLE_FRAME_EN: send all-zero keep-alive frames whenever no requester is pending.
module link_frame_scheduler #(
   parameter int NREQ    = 2,
   parameter int FRAME_W = 49,
   parameter int CNT_W   = 6
) (
   input  logic                  LINK_CLK,
   input  logic                  RESETN,
   link_frame_scheduler_if.master lnk
);
   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_W - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [PTR_W-1:0]   ptr;
   logic [NREQ-1:0]    gnt;
   logic               frame_done;
   logic [FRAME_W-1:0] sh;

   logic [PTR_W-1:0]   win_idx;
   logic [PTR_W-1:0]   ptr_nxt;
   logic [NREQ-1:0]    win_oh;
   logic [FRAME_W-1:0] win_data;
   logic               any_req;
   logic               last_bit;
   logic               start_frame;
   logic               load_req;
   logic               load_null;
   int                 off;
   int                 best_off;

   // Winner is the requester with the smallest rotating distance from ptr.
   always_comb begin
      win_idx  = '0;
      off      = 0;
      best_off = NREQ;
      for (int j = 0; j < NREQ; j++) begin
         if (lnk.REQ[j]) begin
            off = j - int'(ptr);
            if (off < 0) off = off + NREQ;
            if (off < best_off) begin
               best_off = off;
               win_idx  = PTR_W'(j);
            end
         end
      end
   end

   always_comb begin
      win_oh   = '0;
      win_data = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (PTR_W'(j) == win_idx) begin
            win_oh[j] = any_req;
            win_data  = lnk.REQ_DATA[j*FRAME_W +: FRAME_W];
         end
      end
   end

   assign any_req     = |lnk.REQ;
   assign ptr_nxt     = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
   assign last_bit    = (state == SHIFT) && (cnt == LAST_CNT);
   assign start_frame = (state == IDLE) || last_bit;
   assign load_req    = start_frame && any_req;
`ifdef IDLE_FRAME_EN
   assign load_null   = start_frame && !any_req;
`else
   assign load_null   = 1'b0;
`endif

   always_ff @(posedge LINK_CLK or negedge RESETN) begin
      if (!RESETN) begin
         state      <= IDLE;
         cnt        <= '0;
         ptr        <= '0;
         gnt        <= '0;
         frame_done <= 1'b0;
      end else begin
         gnt        <= '0;
         frame_done <= last_bit;
         if (state == SHIFT) cnt <= cnt + 1'b1;
         if (load_req) begin
            gnt   <= win_oh;
            ptr   <= ptr_nxt;
            cnt   <= '0;
            state <= SHIFT;
         end else if (load_null) begin
            cnt   <= '0;
            state <= SHIFT;
         end else if (last_bit) begin
            cnt   <= '0;
            state <= IDLE;
         end
      end
   end

   // Payload register carries no reset: it is only observed while state is SHIFT.
   always_ff @(posedge LINK_CLK) begin
      if (load_req)
         sh <= win_data;
      else if (load_null)
         sh <= '0;
      else if (state == SHIFT)
         sh <= {sh[FRAME_W-2:0], 1'b0};
   end

   assign lnk.GNT        = gnt;
   assign lnk.FRAME_DONE = frame_done;
   assign lnk.BUSY       = (state == SHIFT);
   assign lnk.S_OUT      = (state == SHIFT) && sh[FRAME_W-1];
   assign lnk.SYNC       = last_bit;
endmodule

// File: tb/tb_link_frame_scheduler.sv
// Directed bench for link_frame_scheduler: reset, single frame, round-robin, mid-frame reset, data hold.
module tb_link_frame_scheduler;
   localparam int NREQ = 2;
   localparam int FW   = 49;

   logic LINK_CLK = 1'b0;
   logic RESETN   = 1'b0;
   int   n_chk    = 0;
   int   n_fail   = 0;

   link_frame_scheduler_if #(.NREQ(NREQ), .FRAME_W(FW)) lnk ();

   link_frame_scheduler #(.NREQ(NREQ), .FRAME_W(FW), .CNT_W(6)) dut (
      .LINK_CLK (LINK_CLK),
      .RESETN   (RESETN),
      .lnk      (lnk)
   );

   always #5 LINK_CLK = ~LINK_CLK;

   logic [FW-1:0] d0, d1;
   assign lnk.REQ_DATA = {d1, d0};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge LINK_CLK);
      #1;
   endtask

   task automatic do_reset();
      RESETN = 1'b0;
      step();
      step();
      RESETN = 1'b1;
   endtask

   // Called one cycle after a grant edge; leaves the bench one cycle after the frame's final edge.
   task automatic get_frame(output logic [FW-1:0] data, output logic [FW-1:0] syncv,
                            output logic [FW-1:0] busyv, output logic gnt_later);
      data = '0; syncv = '0; busyv = '0; gnt_later = 1'b0;
      for (int k = 0; k < FW; k++) begin
         data  = {data[FW-2:0], lnk.S_OUT};
         syncv = {syncv[FW-2:0], lnk.SYNC};
         busyv = {busyv[FW-2:0], lnk.BUSY};
         if (k > 0 && lnk.GNT != '0) gnt_later = 1'b1;
         step();
      end
   endtask

   task automatic check_frame(input string tag, input logic [FW-1:0] exp);
      logic [FW-1:0] data, syncv, busyv;
      logic          gl;
      get_frame(data, syncv, busyv, gl);
      chk({tag, "_data"}, 64'(data), 64'(exp));
      chk({tag, "_sync"}, 64'(syncv), 64'd1);
      chk({tag, "_busy"}, 64'(busyv), 64'({FW{1'b1}}));
      chk({tag, "_gnt1"}, 64'(gl), 64'd0);
   endtask

   logic [FW-1:0] syncv20;
   int            bad;
   int            nsync;
   int            last_c;
   logic          seen;

   initial begin
      lnk.REQ = 2'b11;
      d0 = 49'h0_A5A5_0F0F_3C3C;
      d1 = 49'h1_5A5A_F0F0_C3C3;

      // Reset with both requesters pending
      step();
      step();
      chk("rst_outs", 64'({lnk.GNT, lnk.S_OUT, lnk.SYNC, lnk.BUSY, lnk.FRAME_DONE}), 64'd0);
      RESETN = 1'b1;
      step();
      chk("rst_gnt", 64'(lnk.GNT), 64'd1);
      lnk.REQ = 2'b00;
      check_frame("rst_f", 49'h0_A5A5_0F0F_3C3C);
      chk("rst_end", 64'({lnk.FRAME_DONE, lnk.BUSY, lnk.GNT}), 64'b1000);
      step();
      chk("rst_fd_pulse", 64'(lnk.FRAME_DONE), 64'd0);

      // Single frame
      d0 = 49'h1_2345_6789_ABCD;
      lnk.REQ = 2'b01;
      step();
      chk("single_gnt", 64'(lnk.GNT), 64'd1);
      lnk.REQ = 2'b00;
      check_frame("single", 49'h1_2345_6789_ABCD);
      chk("single_idle", 64'({lnk.BUSY, lnk.S_OUT}), 64'd0);

      // Round-robin, back-to-back frames
      do_reset();
      d0 = 49'h1_0000_DEAD_BEEF;
      d1 = 49'h0_FFFF_1234_0001;
      lnk.REQ = 2'b11;
      step();
      for (int f = 0; f < 4; f++) begin
         chk("rr_gnt", 64'(lnk.GNT), (f % 2 == 0) ? 64'd1 : 64'd2);
         if (f == 3) lnk.REQ = 2'b00;
         check_frame("rr", (f % 2 == 0) ? 49'h1_0000_DEAD_BEEF : 49'h0_FFFF_1234_0001);
         chk("rr_fd", 64'(lnk.FRAME_DONE), 64'd1);
      end
      chk("rr_end_busy", 64'(lnk.BUSY), 64'd0);

      // Reset during bit 20; ptr would otherwise favour requester 1
      lnk.REQ = 2'b01;
      step();
      chk("mid_gnt", 64'(lnk.GNT), 64'd1);
      lnk.REQ = 2'b11;
      syncv20 = '0;
      for (int k = 0; k < 20; k++) begin
         syncv20 = {syncv20[FW-2:0], lnk.SYNC};
         step();
      end
      chk("mid_busy_pre", 64'(lnk.BUSY), 64'd1);
      chk("mid_nosync", 64'(syncv20), 64'd0);
      #2;
      RESETN = 1'b0;
      #1;
      chk("mid_rst_outs", 64'({lnk.S_OUT, lnk.SYNC, lnk.BUSY, lnk.GNT, lnk.FRAME_DONE}), 64'd0);
      step();
      RESETN = 1'b1;
      step();
      chk("mid_after_gnt", 64'(lnk.GNT), 64'd1);
      lnk.REQ = 2'b00;
      check_frame("mid_after", 49'h1_0000_DEAD_BEEF);

      // Payload sampled only at the grant edge
      d0 = 49'h0_1357_9BDF_2468;
      lnk.REQ = 2'b01;
      step();
      chk("hold_gnt", 64'(lnk.GNT), 64'd1);
      d0 = 49'h1_FFFF_0000_FFFF;
      lnk.REQ = 2'b00;
      check_frame("hold", 49'h0_1357_9BDF_2468);

`ifdef IDLE_FRAME_EN
      // Keep-alive frames while nothing is requested
      lnk.REQ = 2'b00;
      do_reset();
      bad = 0; nsync = 0; last_c = -1;
      for (int c = 0; c < 200; c++) begin
         step();
         if (lnk.GNT != '0 || lnk.S_OUT || !lnk.BUSY) bad = 1;
         if (lnk.SYNC) begin
            if (last_c >= 0 && c - last_c != FW) bad = 1;
            last_c = c;
            nsync++;
         end
      end
      chk("ka_clean", 64'(bad), 64'd0);
      chk("ka_nsync", 64'(nsync), 64'd4);
      lnk.REQ = 2'b01;
      d0 = 49'h0_0BAD_CAFE_0001;
      seen = 1'b0; bad = 0;
      for (int c = 0; c < 60 && !seen; c++) begin
         if (lnk.SYNC) seen = 1'b1;
         else begin
            if (lnk.GNT != '0) bad = 1;
            step();
         end
      end
      chk("ka_wait_sync", 64'(seen), 64'd1);
      chk("ka_no_early_gnt", 64'(bad), 64'd0);
      step();
      chk("ka_req_gnt", 64'(lnk.GNT), 64'd1);
      lnk.REQ = 2'b00;
      check_frame("ka_req", 49'h0_0BAD_CAFE_0001);
`else
      // Link stays quiet with no requests
      lnk.REQ = 2'b00;
      do_reset();
      bad = 0;
      for (int c = 0; c < 100; c++) begin
         step();
         if (lnk.SYNC || lnk.BUSY || lnk.S_OUT || lnk.GNT != '0 || lnk.FRAME_DONE) bad = 1;
      end
      chk("idle_quiet", 64'(bad), 64'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
